decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 69 ++++++
 rtl/decode_stage_if.sv | 46 ++++
 rtl/decode_stage_reg_file.sv | 48 ++++
 rtl/decode_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats, ID/EX record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package decode_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // RV32I base opcodes; the EX stage keys off the same constants
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic              illegal;
  } idex_t;

  // Which immediate layout an opcode carries; R-type and unknown opcodes have none
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    imm_fmt_e fmt;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic opcode_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch, EX-feedback, WB write port and ID/EX outputs around the decode stage.
// Latency: n/a (wiring only).
// Backpressure: stall flows from slave (decode) back to master (fetch side).
interface decode_stage_if;
  import decode_stage_pkg::*;

  // fetch side
  logic [XLEN-1:0]   PC_in;
  logic [XLEN-1:0]   instr;
  logic              valid_in;
  logic              stall;
  // EX feedback
  logic              flush;
  logic              ex_memRead;
  logic [REG_AW-1:0] ex_rd;
  // WB register-file write port
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  // ID/EX register
  logic              valid_out;
  logic [XLEN-1:0]   PC_out;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              illegal;

  modport master (
    output PC_in, instr, valid_in, flush, ex_memRead, ex_rd, wb_en, wb_rd, wb_data,
    input  stall, valid_out, PC_out, rs1_val, rs2_val, imm, rs1, rs2, rd,
           opcode, funct3, funct7_5, illegal
  );

  modport slave (
    input  PC_in, instr, valid_in, flush, ex_memRead, ex_rd, wb_en, wb_rd, wb_data,
    output stall, valid_out, PC_out, rs1_val, rs2_val, imm, rs1, rs2, rd,
           opcode, funct3, funct7_5, illegal
  );

endinterface

// File: rtl/decode_stage_reg_file.sv
// 32x32 integer register file, x0 hard-wired to zero, write-through bypass on reads.
// Latency: reads combinational, write lands at the clock edge.
// Backpressure: none; writes are always accepted, even while decode is stalled or flushed.
module reg_file
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_vld,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_dat,
  input  logic [REG_AW-1:0] rd1_addr,
  output logic [XLEN-1:0]   rd1_dat,
  input  logic [REG_AW-1:0] rd2_addr,
  output logic [XLEN-1:0]   rd2_dat
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  // Next register contents: one write per cycle, x0 writes dropped
  always_comb begin
    regs_d = regs_q;
    if (wr_vld && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_dat;
    end
  end

  // Register array update; reset wins over a concurrent write
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write to the read address is forwarded
  always_comb begin
    rd1_dat = regs_q[rd1_addr];
    rd2_dat = regs_q[rd2_addr];
    if (wr_vld && (wr_addr == rd1_addr)) rd1_dat = wr_dat;
    if (wr_vld && (wr_addr == rd2_addr)) rd2_dat = wr_dat;
    if (rd1_addr == '0) rd1_dat = '0;
    if (rd2_addr == '0) rd2_dat = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: field split, immediate generation, register read, load-use stall, ID/EX register.
// Latency: 1 cycle from PC_in/instr to the ID/EX outputs; stall is combinational.
// Backpressure: a load-use hazard raises stall and inserts a bubble; flush overrides stall.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave dif
);

  logic [6:0]        opc;
  logic [REG_AW-1:0] rs1_a;
  logic [REG_AW-1:0] rs2_a;
  logic [XLEN-1:0]   rs1_rdat;
  logic [XLEN-1:0]   rs2_rdat;
  logic [XLEN-1:0]   imm_dec;
  logic              rs1_used;
  logic              rs2_used;
  logic              hazard;
  logic              stall;
  idex_t             idex_d;
  idex_t             idex_q;

  assign opc   = dif.instr[6:0];
  assign rs1_a = dif.instr[19:15];
  assign rs2_a = dif.instr[24:20];

  reg_file u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .wr_vld   (dif.wb_en),
    .wr_addr  (dif.wb_rd),
    .wr_dat   (dif.wb_data),
    .rd1_addr (rs1_a),
    .rd1_dat  (rs1_rdat),
    .rd2_addr (rs2_a),
    .rd2_dat  (rs2_rdat)
  );

  // Sign-extended immediate for the opcode's format; zero when there is none
  always_comb begin
    imm_dec = '0;
    case (imm_fmt_of(opc))
      IMM_I: imm_dec = {{20{dif.instr[31]}}, dif.instr[31:20]};
      IMM_S: imm_dec = {{20{dif.instr[31]}}, dif.instr[31:25], dif.instr[11:7]};
      IMM_B: imm_dec = {{19{dif.instr[31]}}, dif.instr[31], dif.instr[7],
                        dif.instr[30:25], dif.instr[11:8], 1'b0};
      IMM_U: imm_dec = {dif.instr[31:12], 12'h000};
      IMM_J: imm_dec = {{11{dif.instr[31]}}, dif.instr[31], dif.instr[19:12],
                        dif.instr[20], dif.instr[30:21], 1'b0};
      default: imm_dec = '0;
    endcase
  end

  // Load-use hazard: a load in EX writes a register this instruction actually reads
  always_comb begin
    rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    rs2_used = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    hazard   = dif.valid_in && dif.ex_memRead && (dif.ex_rd != '0) &&
               (((dif.ex_rd == rs1_a) && rs1_used) || ((dif.ex_rd == rs2_a) && rs2_used));
  end

  // A flushed instruction is discarded anyway, so it never needs to hold fetch
  assign stall     = hazard && !dif.flush && !reset;
  assign dif.stall = stall;

  // Next ID/EX content: decoded instruction, or an all-zero bubble
  always_comb begin
    idex_d = '0;
    if (dif.valid_in && !dif.flush && !stall) begin
      idex_d.valid    = 1'b1;
      idex_d.pc       = dif.PC_in;
      idex_d.rs1_val  = rs1_rdat;
      idex_d.rs2_val  = rs2_rdat;
      idex_d.imm      = imm_dec;
      idex_d.rs1      = rs1_a;
      idex_d.rs2      = rs2_a;
      idex_d.rd       = dif.instr[11:7];
      idex_d.opcode   = opc;
      idex_d.funct3   = dif.instr[14:12];
      idex_d.funct7_5 = dif.instr[30];
      idex_d.illegal  = !opcode_legal(opc);
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign dif.valid_out = idex_q.valid;
  assign dif.PC_out    = idex_q.pc;
  assign dif.rs1_val   = idex_q.rs1_val;
  assign dif.rs2_val   = idex_q.rs2_val;
  assign dif.imm       = idex_q.imm;
  assign dif.rs1       = idex_q.rs1;
  assign dif.rs2       = idex_q.rs2;
  assign dif.rd        = idex_q.rd;
  assign dif.opcode    = idex_q.opcode;
  assign dif.funct3    = idex_q.funct3;
  assign dif.funct7_5  = idex_q.funct7_5;
  assign dif.illegal   = idex_q.illegal;

endmodule
